// File: rtl/i2c_config_sequencer.sv
// Walks the WM8731 register table and hands each {device addr, reg word} to I2C_Control.
// Optional per-entry retry is enabled by defining I2C_CFG_RETRY_EN.
module i2c_config_sequencer #(
  parameter logic [7:0] DEV_ADDR       = 8'h34,
  parameter int         NUM_REGS       = 11,
  parameter int         INIT_WAIT      = 40,
  parameter int         GAP_CYCLES     = 4,
  parameter int         TIMEOUT_CYCLES = 64,
  parameter int         MAX_RETRY      = 3
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        TX_DONE,
  input  logic        ACK,
  input  logic        RESTART,
  output logic [23:0] DATA_REG,
  output logic        START_TX,
  output logic [3:0]  REG_INDEX,
  output logic        CONFIG_DONE,
  output logic        CONFIG_ERROR
);

  typedef enum logic [2:0] {
    ST_POWERUP,
    ST_LOAD,
    ST_START,
    ST_WAIT_DONE,
    ST_CHECK,
    ST_GAP,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam logic [3:0]  LAST_INDEX   = 4'(NUM_REGS - 1);
  localparam logic [15:0] INIT_LAST    = 16'(INIT_WAIT - 1);
  localparam logic [15:0] GAP_LAST     = 16'(GAP_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  if (NUM_REGS < 1 || NUM_REGS > 16) begin : g_bad_num_regs
    $error("NUM_REGS must be 1..16");
  end
  if (INIT_WAIT < 34) begin : g_bad_init_wait
    $error("INIT_WAIT must cover a full frame (>=34)");
  end
  if (GAP_CYCLES < 2) begin : g_bad_gap
    $error("GAP_CYCLES must be >=2");
  end
  if (TIMEOUT_CYCLES < 1 || MAX_RETRY < 0 || MAX_RETRY > 15) begin : g_bad_limits
    $error("TIMEOUT_CYCLES must be >=1 and MAX_RETRY 0..15");
  end

  // Codec register writes, {7-bit register, 9-bit data}; entry 0 resets the codec.
  function automatic logic [15:0] table_entry(input logic [3:0] idx);
    case (idx)
      4'd0:    table_entry = 16'h1E00;
      4'd1:    table_entry = 16'h0017;
      4'd2:    table_entry = 16'h0217;
      4'd3:    table_entry = 16'h0479;
      4'd4:    table_entry = 16'h0679;
      4'd5:    table_entry = 16'h0812;
      4'd6:    table_entry = 16'h0A06;
      4'd7:    table_entry = 16'h0C00;
      4'd8:    table_entry = 16'h0E01;
      4'd9:    table_entry = 16'h1002;
      4'd10:   table_entry = 16'h1201;
      default: table_entry = 16'h0000;
    endcase
  endfunction

  state_t      state;
  logic [15:0] wait_cnt;
  logic [15:0] timeout_cnt;
  logic        ack_ok;
  logic        advance;
`ifdef I2C_CFG_RETRY_EN
  localparam logic [3:0] RETRY_LAST = 4'(MAX_RETRY);
  logic [3:0]  retry_cnt;
`endif

  // GAP is shared by three paths; 'advance' says whether leaving it moves to the next entry
  // (after a pass) or reloads the current one (after a retry or a RESTART).
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state        <= ST_POWERUP;
      DATA_REG     <= 24'h0;
      START_TX     <= 1'b0;
      REG_INDEX    <= 4'd0;
      CONFIG_DONE  <= 1'b0;
      CONFIG_ERROR <= 1'b0;
      wait_cnt     <= 16'd0;
      timeout_cnt  <= 16'd0;
      ack_ok       <= 1'b0;
      advance      <= 1'b0;
`ifdef I2C_CFG_RETRY_EN
      retry_cnt    <= 4'd0;
`endif
    end else begin
      START_TX <= 1'b0;
      case (state)
        ST_POWERUP: begin
          if (wait_cnt == INIT_LAST) begin
            wait_cnt <= 16'd0;
            state    <= ST_LOAD;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        ST_LOAD: begin
          DATA_REG <= {DEV_ADDR, table_entry(REG_INDEX)};
          START_TX <= 1'b1;
          state    <= ST_START;
        end
        ST_START: begin
          timeout_cnt <= 16'd0;
          state       <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (TX_DONE) begin
            ack_ok <= ACK;
            state  <= ST_CHECK;
          end else if (timeout_cnt == TIMEOUT_LAST) begin
            ack_ok <= 1'b0;
            state  <= ST_CHECK;
          end else begin
            timeout_cnt <= timeout_cnt + 16'd1;
          end
        end
        ST_CHECK: begin
          if (ack_ok) begin
            advance  <= 1'b1;
            wait_cnt <= 16'd0;
            state    <= ST_GAP;
`ifdef I2C_CFG_RETRY_EN
            retry_cnt <= 4'd0;
`endif
          end else begin
`ifdef I2C_CFG_RETRY_EN
            if (retry_cnt == RETRY_LAST) begin
              CONFIG_ERROR <= 1'b1;
              state        <= ST_ERROR;
            end else begin
              retry_cnt <= retry_cnt + 4'd1;
              advance   <= 1'b0;
              wait_cnt  <= 16'd0;
              state     <= ST_GAP;
            end
`else
            CONFIG_ERROR <= 1'b1;
            state        <= ST_ERROR;
`endif
          end
        end
        ST_GAP: begin
          if (wait_cnt == GAP_LAST) begin
            wait_cnt <= 16'd0;
            if (!advance) begin
              state <= ST_LOAD;
            end else if (REG_INDEX == LAST_INDEX) begin
              CONFIG_DONE <= 1'b1;
              state       <= ST_DONE;
            end else begin
              REG_INDEX <= REG_INDEX + 4'd1;
              state     <= ST_LOAD;
            end
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        ST_DONE, ST_ERROR: begin
          if (RESTART) begin
            CONFIG_DONE  <= 1'b0;
            CONFIG_ERROR <= 1'b0;
            REG_INDEX    <= 4'd0;
            advance      <= 1'b0;
            wait_cnt     <= 16'd0;
            state        <= ST_GAP;
`ifdef I2C_CFG_RETRY_EN
            retry_cnt    <= 4'd0;
`endif
          end
        end
        default: state <= ST_POWERUP;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Scoreboard bench for i2c_config_sequencer with a behavioural I2C_Control/slave frame model.
// Expectations follow I2C_CFG_RETRY_EN when the bench is built with it defined.
module tb_i2c_config_sequencer;

  localparam int FRAME_CYCLES = 33;
  localparam int INIT_WAIT    = 40;
  localparam int GAP_CYCLES   = 4;
  localparam int BUDGET       = 3000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        tx_done = 1'b0;
  logic        ack = 1'b0;
  logic        restart = 1'b0;
  logic [23:0] data_reg;
  logic        start_tx;
  logic [3:0]  reg_index;
  logic        config_done;
  logic        config_error;

  always #5 clock = ~clock;

  i2c_config_sequencer dut (
    .CLOCK       (clock),
    .RESET       (reset),
    .TX_DONE     (tx_done),
    .ACK         (ack),
    .RESTART     (restart),
    .DATA_REG    (data_reg),
    .START_TX    (start_tx),
    .REG_INDEX   (reg_index),
    .CONFIG_DONE (config_done),
    .CONFIG_ERROR(config_error)
  );

  logic [15:0] codec_table [0:10] = '{16'h1E00, 16'h0017, 16'h0217, 16'h0479, 16'h0679,
                                      16'h0812, 16'h0A06, 16'h0C00, 16'h0E01, 16'h1002,
                                      16'h1201};

  int errors = 0;
  int checks = 0;
  int exp_q[$];
  int cyc = 0;
  int last_reset_cyc = 0;
  int last_done_cyc = -1000;
  bit first_pending = 1'b1;
  bit prev_start = 1'b0;
  int nack_entry = -1;
  int nack_left = 0;
  int stuck_entry = -1;
  int slave_entry;
  logic slave_ack;
  int mon_idx;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic pushRange(input int first, input int last);
    for (int i = first; i <= last; i++) exp_q.push_back(i);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_data_reg"}, data_reg, 0);
    checkOutput({tag, "_start_tx"}, start_tx, 0);
    checkOutput({tag, "_reg_index"}, reg_index, 0);
    checkOutput({tag, "_done"}, config_done, 0);
    checkOutput({tag, "_error"}, config_error, 0);
  endtask

  // Optionally pulses RESTART, then waits (bounded) for DONE or ERROR.
  task automatic applyStimulus(input string name, input bit do_restart);
    int n;
    n = 0;
    if (do_restart) begin
      restart = 1'b1;
      tick(1);
      restart = 1'b0;
    end
    while (!(config_done || config_error) && n < BUDGET) begin
      tick(1);
      n++;
    end
    if (n >= BUDGET) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout: no DONE/ERROR within %0d cycles", name, BUDGET);
    end
  endtask

  task automatic checkFinal(input string name, input bit exp_done, input int exp_index);
    checkOutput({name, "_done"}, config_done, exp_done);
    checkOutput({name, "_error"}, config_error, !exp_done);
    checkOutput({name, "_reg_index"}, reg_index, exp_index);
    checkOutput({name, "_pending_starts"}, exp_q.size(), 0);
  endtask

  // Monitor: every START_TX pops the next expected entry from the scoreboard.
  initial begin : monitor
    forever begin
      @(negedge clock);
      cyc++;
      if (reset) begin
        first_pending  = 1'b1;
        last_reset_cyc = cyc;
      end
      if (tx_done) last_done_cyc = cyc;
      if (start_tx) begin
        checkOutput("start_back_to_back", prev_start, 0);
        checkOutput("done_error_exclusive", config_done & config_error, 0);
        if (first_pending) begin
          checkOutput("init_wait_spacing", (cyc - last_reset_cyc) >= INIT_WAIT, 1);
          first_pending = 1'b0;
        end else begin
          checkOutput("gap_spacing", (cyc - last_done_cyc) >= GAP_CYCLES + 1, 1);
        end
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_start: got entry %0d expected no START_TX", reg_index);
        end else begin
          mon_idx = exp_q.pop_front();
          checkOutput("data_reg", data_reg, {8'h34, codec_table[mon_idx]});
          checkOutput("reg_index", reg_index, mon_idx);
        end
      end
      prev_start = start_tx;
    end
  end

  // Frame model standing in for I2C_Control plus the codec; frames are not cut short by RESET.
  initial begin : slave
    forever begin
      @(negedge clock);
      if (start_tx && !reset) begin
        slave_entry = int'(reg_index);
        if (slave_entry != stuck_entry) begin
          slave_ack = 1'b1;
          if (slave_entry == nack_entry && nack_left > 0) begin
            slave_ack = 1'b0;
            nack_left--;
          end
          tick(FRAME_CYCLES);
          tx_done = 1'b1;
          ack     = slave_ack;
          tick(1);
          tx_done = 1'b0;
          ack     = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int n;
    // All entries acked after power-up.
    tick(3);
    checkResetValues("reset");
    pushRange(0, 10);
    reset = 1'b0;
    applyStimulus("all_ack", 1'b0);
    checkFinal("all_ack", 1'b1, 10);

    // RESTART from DONE reruns the whole table.
    pushRange(0, 10);
    applyStimulus("restart_done", 1'b1);
    checkFinal("restart_done", 1'b1, 10);

    // Entry 2 always NACKs.
    nack_entry = 2;
    nack_left  = 100;
    pushRange(0, 2);
`ifdef I2C_CFG_RETRY_EN
    pushRange(2, 2);
    pushRange(2, 2);
    pushRange(2, 2);
`endif
    applyStimulus("nack_always", 1'b1);
    checkFinal("nack_always", 1'b0, 2);
    nack_entry = -1;
    nack_left  = 0;

    // Entry 3 never completes; the DUT's timeout must fail the attempt.
    stuck_entry = 3;
    pushRange(0, 3);
`ifdef I2C_CFG_RETRY_EN
    pushRange(3, 3);
    pushRange(3, 3);
    pushRange(3, 3);
`endif
    applyStimulus("stuck_done", 1'b1);
    checkFinal("stuck_done", 1'b0, 3);
    stuck_entry = -1;

    // Entry 4 NACKs once.
    nack_entry = 4;
    nack_left  = 1;
`ifdef I2C_CFG_RETRY_EN
    pushRange(0, 4);
    pushRange(4, 10);
    applyStimulus("nack_once", 1'b1);
    checkFinal("nack_once", 1'b1, 10);
`else
    pushRange(0, 4);
    applyStimulus("nack_once", 1'b1);
    checkFinal("nack_once", 1'b0, 4);
`endif
    nack_entry = -1;
    nack_left  = 0;

    // RESET during entry 5's frame, then a full rerun; RESTART while running is ignored.
    pushRange(0, 10);
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    n = 0;
    while (!(start_tx && reg_index == 4'd5) && n < BUDGET) begin
      tick(1);
      n++;
    end
    checkOutput("reach_entry5", n < BUDGET, 1);
    tick(10);
    reset = 1'b1;
    tick(3);
    checkResetValues("midframe_reset");
    exp_q.delete();
    pushRange(0, 10);
    reset = 1'b0;
    tick(5);
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    applyStimulus("rerun_after_reset", 1'b0);
    checkFinal("rerun_after_reset", 1'b1, 10);

    tick(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
